// File: rtl/hc595_ctrl.sv
// hc595_ctrl: serialises a parallel word into a 74HC595 chain.
// The word is shifted MSB first on ds/shcp, then latched with a single stcp pulse.
// Every output is registered from next-state values, so pin timing lines up
// with the state the FSM has just entered.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for start; shcp/stcp low, busy low
// SHIFT_LO | shcp low half-period; ds holds the current bit
// SHIFT_HI | shcp high half-period; the 595 samples ds on the rise
// LATCH    | stcp high for CLK_DIV cycles to commit the shifted word
// DONE     | one-cycle done pulse; oe_n enabled from here on

module hc595_ctrl #(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [DATA_W-1:0] data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              ds,
    output logic              shcp,
    output logic              stcp,
    output logic              oe_n
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(DATA_W + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_LATCH,
        ST_DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  div_next;
    logic [BIT_W-1:0]  bit_cnt;
    logic [BIT_W-1:0]  bit_next;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_next;
    logic [DATA_W-1:0] shreg_shl;
    logic              ds_next;
    logic              oe_n_next;
    logic              div_tc;

    // Terminal count of the divide counter and the pre-shifted register image
    // (the next bit must reach ds on the same edge the register shifts).
    always_comb begin
        div_tc    = (div_cnt == DIV_LAST);
        shreg_shl = shreg << 1;
    end

    // Next-state, counter and datapath decisions.
    always_comb begin
        state_next = state;
        div_next   = div_cnt;
        bit_next   = bit_cnt;
        shreg_next = shreg;
        ds_next    = ds;
        oe_n_next  = oe_n;

        case (state)
            ST_IDLE: begin
                div_next = '0;
                ds_next  = 1'b0;
                if (start) begin
                    state_next = ST_SHIFT_LO;
                    shreg_next = data;
                    bit_next   = '0;
                    ds_next    = data[DATA_W-1];
                end
            end

            ST_SHIFT_LO: begin
                if (div_tc) begin
                    state_next = ST_SHIFT_HI;
                    div_next   = '0;
                end else begin
                    div_next = div_cnt + DIV_ONE;
                end
            end

            ST_SHIFT_HI: begin
                if (div_tc) begin
                    div_next = '0;
                    if (bit_cnt == BIT_LAST) begin
                        state_next = ST_LATCH;
                        ds_next    = 1'b0;
                    end else begin
                        state_next = ST_SHIFT_LO;
                        bit_next   = bit_cnt + BIT_ONE;
                        shreg_next = shreg_shl;
                        ds_next    = shreg_shl[DATA_W-1];
                    end
                end else begin
                    div_next = div_cnt + DIV_ONE;
                end
            end

            ST_LATCH: begin
                ds_next = 1'b0;
                if (div_tc) begin
                    state_next = ST_DONE;
                    div_next   = '0;
                    oe_n_next  = 1'b0;
                end else begin
                    div_next = div_cnt + DIV_ONE;
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
                div_next   = '0;
                ds_next    = 1'b0;
            end

            default: begin
                state_next = ST_IDLE;
                div_next   = '0;
                bit_next   = '0;
                ds_next    = 1'b0;
            end
        endcase
    end

    // State and internal counters; reset abandons any word in flight.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= ST_IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_next;
            div_cnt <= div_next;
            bit_cnt <= bit_next;
            shreg   <= shreg_next;
        end
    end

    // Registered pin outputs, decoded from the state being entered.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
            ds   <= 1'b0;
            shcp <= 1'b0;
            stcp <= 1'b0;
            oe_n <= 1'b1;
        end else begin
            busy <= (state_next != ST_IDLE);
            done <= (state_next == ST_DONE);
            ds   <= ds_next;
            shcp <= (state_next == ST_SHIFT_HI);
            stcp <= (state_next == ST_LATCH);
            oe_n <= oe_n_next;
        end
    end

endmodule

// File: tb/tb_hc595_ctrl.sv
// tb_hc595_ctrl: checks two hc595_ctrl instances (16-bit/div 4 and 8-bit/div 1)
// against a cycle-indexed model derived from the transfer timing formulas.

module tb_hc595_ctrl;

    localparam int DW_A = 16;
    localparam int CD_A = 4;
    localparam int DW_B = 8;
    localparam int CD_B = 1;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [15:0] data_a    = '0;
    logic [7:0]  data_b    = '0;
    logic        start_a   = 1'b0;
    logic        start_b   = 1'b0;
    logic        busy_a, done_a, ds_a, shcp_a, stcp_a, oe_n_a;
    logic        busy_b, done_b, ds_b, shcp_b, stcp_b, oe_n_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_done_cyc = 0;
    bit oe_low [2];

    typedef struct {
        int          sel;
        logic [15:0] word;
        int          ign_at;
        logic [15:0] ign_word;
        logic [15:0] exp_word;
        int          exp_rises;
    } vec_t;

    vec_t tbl [6];

    hc595_ctrl #(.DATA_W(DW_A), .CLK_DIV(CD_A)) u_dut_a (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .data(data_a), .start(start_a),
        .busy(busy_a), .done(done_a), .ds(ds_a), .shcp(shcp_a), .stcp(stcp_a), .oe_n(oe_n_a)
    );

    hc595_ctrl #(.DATA_W(DW_B), .CLK_DIV(CD_B)) u_dut_b (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .data(data_b), .start(start_b),
        .busy(busy_b), .done(done_b), .ds(ds_b), .shcp(shcp_b), .stcp(stcp_b), .oe_n(oe_n_b)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // {busy, done, shcp, stcp, ds, oe_n}
    function automatic logic [5:0] outs(input int sel);
        if (sel != 0) return {busy_b, done_b, shcp_b, stcp_b, ds_b, oe_n_b};
        return {busy_a, done_a, shcp_a, stcp_a, ds_a, oe_n_a};
    endfunction

    task automatic chk_rst(input string tag);
        chk({tag, "_a"}, {26'd0, outs(0)}, 32'h1);
        chk({tag, "_b"}, {26'd0, outs(1)}, 32'h1);
    endtask

    task automatic drive(input int sel, input logic s, input logic [15:0] d);
        if (sel != 0) begin
            start_b = s;
            data_b  = d[7:0];
        end else begin
            start_a = s;
            data_a  = d;
        end
    endtask

    // Starts a transfer of w (accepted on the next edge) and checks every cycle
    // until the IDLE cycle after DONE. abort_at>0 asserts reset after that cycle.
    task automatic xfer(input int sel, input logic [15:0] w, input int ign_at,
                        input logic [15:0] ign_w, input bit keep, input logic [15:0] next_w,
                        input int abort_at, input logic [15:0] exp_w, input int exp_rises);
        int          dw, cd, p, last, rises;
        logic [15:0] got, mask;
        logic [5:0]  act, expv;
        logic        prev_shcp, m, eds, e_busy, e_done, e_shcp, e_stcp, e_oe;
        dw   = (sel != 0) ? DW_B : DW_A;
        cd   = (sel != 0) ? CD_B : CD_A;
        mask = (sel != 0) ? 16'h00FF : 16'hFFFF;
        p    = 2 * dw * cd;
        last = p + cd + 2;
        drive(sel, 1'b1, w);
        act       = outs(sel);
        prev_shcp = act[3];
        rises     = 0;
        got       = '0;
        for (int n = 1; n <= last; n++) begin
            @(posedge sys_clk);
            #1;
            act    = outs(sel);
            e_busy = (n <= p + cd + 1);
            e_done = (n == p + cd + 1);
            e_shcp = (n <= p) && (((n - 1) % (2 * cd)) >= cd);
            e_stcp = (n > p) && (n <= p + cd);
            m      = (n <= p + cd);
            eds    = (n <= p) ? w[dw - 1 - (n - 1) / (2 * cd)] : 1'b0;
            e_oe   = !(oe_low[sel] || (n >= p + cd + 1));
            expv   = {e_busy, e_done, e_shcp, e_stcp, eds & m, e_oe};
            chk($sformatf("dut%0d_w%h_cyc%0d", sel, w, n),
                {26'd0, act[5:2], act[1] & m, act[0]}, {26'd0, expv});
            if (act[3] && !prev_shcp) begin
                got = {got[14:0], act[1]};
                rises++;
            end
            prev_shcp = act[3];
            if (act[4]) last_done_cyc = cyc;
            if (n == abort_at) begin
                sys_rst_n = 1'b0;
                #1;
                chk_rst("async_reset");
                oe_low[0] = 1'b0;
                oe_low[1] = 1'b0;
                drive(sel, 1'b0, '0);
                return;
            end
            if (n == last)        drive(sel, keep, next_w);
            else if (n == ign_at) drive(sel, 1'b1, ign_w);
            else                  drive(sel, keep, 16'($urandom));
        end
        oe_low[sel] = 1'b1;
        chk($sformatf("dut%0d_word_%h", sel, w), {16'd0, got & mask}, {16'd0, exp_w});
        chk($sformatf("dut%0d_rises_%h", sel, w), rises, exp_rises);
    endtask

    initial begin
        int          sel, ign, d1;
        logic [15:0] w;

        tbl[0] = '{0, 16'hA5C3,  50, 16'hFFFF, 16'hA5C3, 16};
        tbl[1] = '{0, 16'h0000,   1, 16'hFFFF, 16'h0000, 16};
        tbl[2] = '{0, 16'hFFFF, 133, 16'h0000, 16'hFFFF, 16};
        tbl[3] = '{0, 16'h0001,   0, 16'h0000, 16'h0001, 16};
        tbl[4] = '{1, 16'h0081,   0, 16'h0000, 16'h0081,  8};
        tbl[5] = '{1, 16'h00FF,  17, 16'h0000, 16'h00FF,  8};
        oe_low[0] = 1'b0;
        oe_low[1] = 1'b0;

        // reset held for 3 cycles, then 10 quiet idle cycles
        repeat (3) @(posedge sys_clk);
        #1;
        chk_rst("in_reset");
        sys_rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge sys_clk);
            #1;
            chk_rst($sformatf("idle%0d", i));
        end

        // table-driven transfers
        for (int i = 0; i < 6; i++)
            xfer(tbl[i].sel, tbl[i].word, tbl[i].ign_at, tbl[i].ign_word, 1'b0, 16'h0000,
                 0, tbl[i].exp_word, tbl[i].exp_rises);

        // randomized transfers with a stray start somewhere inside
        for (int i = 0; i < 6; i++) begin
            sel = int'($urandom_range(0, 1));
            w   = 16'($urandom);
            if (sel != 0) w[15:8] = 8'h00;
            ign = int'($urandom_range(1, (sel != 0) ? 18 : 133));
            xfer(sel, w, ign, 16'($urandom), 1'b0, 16'h0000, 0, w, (sel != 0) ? DW_B : DW_A);
        end

        // reset in the middle of a transfer, then a clean transfer
        xfer(0, 16'hA5C3, 0, 16'h0000, 1'b0, 16'h0000, 60, 16'hA5C3, 16);
        repeat (2) @(posedge sys_clk);
        #1;
        chk_rst("rst_hold");
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        chk_rst("rst_release");
        xfer(0, 16'h0001, 0, 16'h0000, 1'b0, 16'h0000, 0, 16'h0001, 16);

        // start held high: back-to-back transfers
        xfer(0, 16'h1234, 0, 16'h0000, 1'b1, 16'h8000, 0, 16'h1234, 16);
        d1 = last_done_cyc;
        xfer(0, 16'h8000, 0, 16'h0000, 1'b0, 16'h0000, 0, 16'h8000, 16);
        chk("done_spacing", last_done_cyc - d1, 134);

        repeat (3) @(posedge sys_clk);
        #1;
        chk("final_idle_a", {29'd0, busy_a, done_a, stcp_a}, 32'h0);
        chk("final_idle_b", {29'd0, busy_b, done_b, stcp_b}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
